// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID/EX pipeline and the hazard/stall controller.
// master = pipeline side (drives hazard inputs), slave = controller.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_is_md;
    logic             id_reads_hilo;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             br_taken;
    logic             mem_wait;

    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             md_start;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_is_md, id_reads_hilo,
               ex_memread, ex_rd, br_taken, mem_wait,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, md_start,
               md_busy, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_is_md, id_reads_hilo,
               ex_memread, ex_rd, br_taken, mem_wait,
        output pc_we, ifid_we, ifid_flush, idex_bubble, md_start,
               md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / mul-div hazard detection and PC, IF/ID, ID/EX pipeline control
// for the 5-stage MIPS core, with a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic {RUN, MD_BUSY} state_t;

    localparam logic [5:0] MD_LOAD = 6'(MD_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_md_cnt;
    logic [5:0]       w_md_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_lu;
    logic w_mdh;
    logic w_stall;
    logic w_md_start;
    logic w_pc_we;
    logic w_ifid_we;
    logic w_ifid_flush;
    logic w_idex_bubble;

    // Register 0 is hardwired, so a load targeting it can never feed ID.
    assign w_lu = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                  ((bus.ex_rd == bus.id_rs) ||
                   (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
    assign w_mdh      = (r_state == MD_BUSY) && (bus.id_is_md || bus.id_reads_hilo);
    assign w_stall    = w_lu || w_mdh;
    assign w_md_start = rst_n && bus.id_is_md && !w_stall && !bus.mem_wait;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        case (r_state)
            RUN: begin
                if (w_md_start) begin
                    w_state_nxt  = MD_BUSY;
                    w_md_cnt_nxt = MD_LOAD;
                end
            end
            MD_BUSY: begin
                // The unit keeps counting through mem_wait; it is not frozen with the pipe.
                if (r_md_cnt == 6'd0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_md_cnt_nxt = r_md_cnt - 6'd1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_pc_we       = 1'b1;
        w_ifid_we     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        if (!rst_n) begin
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (bus.mem_wait) begin
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
        end else if (w_stall) begin
            // A taken branch is dropped here; it re-resolves once the stall clears.
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_idex_bubble = 1'b1;
        end else if (bus.br_taken) begin
            w_ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            r_state  <= RUN;
            r_md_cnt <= 6'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((w_stall || bus.mem_wait) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.pc_we       = w_pc_we;
    assign bus.ifid_we     = w_ifid_we;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.md_start    = w_md_start;
    assign bus.md_busy     = (r_state == MD_BUSY);
    assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the stall rules.
module tb_hazard_ctrl;
    localparam int MD_LAT  = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       rst_n;
        logic [4:0] rs, rt, rd;
        logic       uses_rt, is_md, rd_hilo, memrd, br, mw;
    } stim_t;

    typedef struct {
        logic             pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy;
        logic [CNT_W-1:0] stall_cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model state: remaining busy cycles of the mul/div unit, raw stall total.
    int md_left     = 0;
    int stall_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s.rst_n = 1'b1; s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd3;
        s.uses_rt = 1'b0; s.is_md = 1'b0; s.rd_hilo = 1'b0;
        s.memrd = 1'b0; s.br = 1'b0; s.mw = 1'b0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_n   = ($urandom_range(0, 49) != 0);
        s.rs      = 5'($urandom_range(0, 3));
        s.rt      = 5'($urandom_range(0, 3));
        s.rd      = 5'($urandom_range(0, 3));
        s.uses_rt = 1'($urandom_range(0, 1));
        s.is_md   = ($urandom_range(0, 4) == 0);
        s.rd_hilo = ($urandom_range(0, 3) == 0);
        s.memrd   = 1'($urandom_range(0, 1));
        s.br      = ($urandom_range(0, 3) == 0);
        s.mw      = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    // Called just after a rising edge: apply one cycle of stimulus, predict, advance model.
    task automatic drive(input stim_t s);
        exp_t e;
        logic lu, busy, stall, start;
        rst_n             = s.rst_n;
        bus.id_rs         = s.rs;
        bus.id_rt         = s.rt;
        bus.id_uses_rt    = s.uses_rt;
        bus.id_is_md      = s.is_md;
        bus.id_reads_hilo = s.rd_hilo;
        bus.ex_memread    = s.memrd;
        bus.ex_rd         = s.rd;
        bus.br_taken      = s.br;
        bus.mem_wait      = s.mw;

        lu    = s.memrd && (s.rd != 0) && ((s.rd == s.rs) || (s.uses_rt && (s.rd == s.rt)));
        busy  = (md_left > 0);
        stall = lu || (busy && (s.is_md || s.rd_hilo));
        start = s.rst_n && s.is_md && !stall && !s.mw;

        if (!s.rst_n)      {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_bubble} = 4'b0011;
        else if (s.mw)     {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_bubble} = 4'b0000;
        else if (stall)    {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_bubble} = 4'b0001;
        else if (s.br)     {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_bubble} = 4'b1110;
        else               {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_bubble} = 4'b1100;
        e.md_start  = start;
        e.md_busy   = busy;
        e.stall_cnt = CNT_W'((stall_total > CNT_MAX) ? CNT_MAX : stall_total);
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (!s.rst_n) begin
            md_left     = 0;
            stall_total = 0;
        end else begin
            if (md_left > 0) md_left--;
            if (start) md_left = MD_LAT;
            if (stall || s.mw) stall_total++;
        end
    endtask

    // Monitor: outputs are valid every cycle, so compare one prediction per falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("pc_we",       32'(bus.pc_we),       32'(e.pc_we));
            check("ifid_we",     32'(bus.ifid_we),     32'(e.ifid_we));
            check("ifid_flush",  32'(bus.ifid_flush),  32'(e.ifid_flush));
            check("idex_bubble", 32'(bus.idex_bubble), 32'(e.idex_bubble));
            check("md_start",    32'(bus.md_start),    32'(e.md_start));
            check("md_busy",     32'(bus.md_busy),     32'(e.md_busy));
            check("stall_cnt",   32'(bus.stall_cnt),   32'(e.stall_cnt));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0; bus.id_is_md = 1'b0;
        bus.id_reads_hilo = 1'b0; bus.ex_memread = 1'b0; bus.ex_rd = '0;
        bus.br_taken = 1'b0; bus.mem_wait = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with random inputs, then release with quiet inputs.
        for (int i = 0; i < 2; i++) begin
            s = rand_stim();
            s.rst_n = 1'b0;
            drive(s);
        end
        drive(quiet());
        drive(quiet());

        // Load-use: real hazard, then r0 target, then rt not used, then rt used.
        s = quiet(); s.rst_n = 1'b0; drive(s);
        s = quiet(); s.memrd = 1'b1; s.rd = 5'd8; s.rs = 5'd8; drive(s);
        check("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        s = quiet(); s.memrd = 1'b1; s.rd = 5'd0; s.rs = 5'd0; drive(s);
        s = quiet(); s.memrd = 1'b1; s.rd = 5'd8; s.rt = 5'd8; s.uses_rt = 1'b0; drive(s);
        s = quiet(); s.memrd = 1'b1; s.rd = 5'd8; s.rt = 5'd8; s.uses_rt = 1'b1; drive(s);

        // Mul/div followed by dependent MFHI.
        s = quiet(); s.rst_n = 1'b0; drive(s);
        s = quiet(); s.is_md = 1'b1; drive(s);
        for (int i = 1; i <= 5; i++) begin
            s = quiet(); s.rd_hilo = 1'b1; drive(s);
        end
        check("md_stall_cnt", 32'(bus.stall_cnt), 32'd4);
        check("md_done_busy", 32'(bus.md_busy),   32'd0);

        // Back-to-back MD: second waits for RUN, then starts immediately.
        s = quiet(); s.is_md = 1'b1;
        for (int i = 0; i < 7; i++) drive(s);

        // Branch together with a load-use hazard, then branch alone.
        s = quiet(); s.rst_n = 1'b0; drive(s);
        s = quiet(); s.br = 1'b1; s.memrd = 1'b1; s.rd = 5'd5; s.rs = 5'd5; drive(s);
        s = quiet(); s.br = 1'b1; drive(s);

        // mem_wait during MD_BUSY.
        s = quiet(); s.rst_n = 1'b0; drive(s);
        s = quiet(); s.is_md = 1'b1; drive(s);
        for (int i = 1; i <= 3; i++) begin
            s = quiet(); s.mw = 1'b1; drive(s);
        end
        drive(quiet());
        check("mw_md_busy",   32'(bus.md_busy),   32'd0);
        check("mw_stall_cnt", 32'(bus.stall_cnt), 32'd3);

        // Saturation of the stall counter.
        s = quiet(); s.rst_n = 1'b0; drive(s);
        s = quiet(); s.mw = 1'b1;
        for (int i = 0; i < 20; i++) drive(s);
        check("sat_stall_cnt", 32'(bus.stall_cnt), 32'(CNT_MAX));

        // Reset asserted mid mul/div.
        s = quiet(); s.is_md = 1'b1; drive(s);
        drive(quiet());
        s = quiet(); s.rst_n = 1'b0; drive(s);
        check("rst_mid_md_busy", 32'(bus.md_busy), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) drive(rand_stim());

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
